// File: rtl/ahb_interconnect.sv
// Single-master AHB-Lite interconnect: address decode, data-phase select,
// response mux and a built-in default slave with a saturating error counter.
module ahb_interconnect #(
  parameter int WIDTH       = 32,
  parameter int N_SLAVES    = 3,
  parameter int REGION_BITS = 12,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [WIDTH-1:0]          HADDR,
  input  logic [1:0]                HTRANS,
  output logic [N_SLAVES-1:0]       HSELx,
  input  logic [N_SLAVES*WIDTH-1:0] HRDATAx,
  input  logic [N_SLAVES-1:0]       HREADYOUTx,
  input  logic [N_SLAVES-1:0]       HRESPx,
  output logic [WIDTH-1:0]          HRDATA,
  output logic                      HREADY,
  output logic                      HRESP,
  input  logic                      err_clr,
  output logic [ERR_CNT_W-1:0]      err_count
);

  localparam int IDX_W = WIDTH - REGION_BITS;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t              r_state;
  ds_state_t              w_state_next;
  logic [N_SLAVES:0]      r_dsel;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_unmapped;
  logic                   w_err_start;
  logic                   w_unused_bits;

  assign w_idx = HADDR[WIDTH-1:REGION_BITS];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_dec
      assign HSELx[gi] = (w_idx == IDX_W'(gi));
    end
  endgenerate

  assign w_unmapped    = ~|HSELx;
  // Only an accepted, active transfer to an unmapped region earns an ERROR.
  assign w_err_start   = HREADY & w_unmapped & HTRANS[1];
  assign w_unused_bits = &{1'b0, HADDR[REGION_BITS-1:0], HTRANS[0]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DS_IDLE: if (w_err_start) w_state_next = DS_ERR1;
      DS_ERR1: w_state_next = DS_ERR2;
      DS_ERR2: w_state_next = w_err_start ? DS_ERR1 : DS_IDLE;
      default: w_state_next = DS_IDLE;
    endcase
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_dsel[i]) begin
        HRDATA = HRDATAx[i*WIDTH +: WIDTH];
        HREADY = HREADYOUTx[i];
        HRESP  = HRESPx[i];
      end
    end
    if (r_dsel[N_SLAVES]) begin
      case (r_state)
        DS_ERR1: begin HREADY = 1'b0; HRESP = 1'b1; end
        DS_ERR2: begin HREADY = 1'b1; HRESP = 1'b1; end
        default: begin HREADY = 1'b1; HRESP = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= DS_IDLE;
      r_dsel    <= {1'b1, {N_SLAVES{1'b0}}};
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (HREADY) r_dsel <= {w_unmapped, HSELx};
      // Clear takes priority over a coincident completed ERROR.
      if (err_clr)
        r_err_cnt <= '0;
      else if (HREADY && HRESP && (r_err_cnt != {ERR_CNT_W{1'b1}}))
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_ahb_interconnect.sv
// Scoreboard bench for ahb_interconnect: stimulus queues per-cycle expected
// responses, a negedge monitor pops and compares them.
module tb_ahb_interconnect;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSELx;
  logic [95:0] HRDATAx;
  logic [2:0]  HREADYOUTx;
  logic [2:0]  HRESPx;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        err_clr;
  logic [1:0]  err_count;
  logic [31:0] sd0, sd1, sd2;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [31:0] D0 = 32'hA5A5_A5A5;
  localparam logic [31:0] D1 = 32'h1111_1111;

  assign HRDATAx = {sd2, sd1, sd0};

  ahb_interconnect #(.WIDTH(32), .N_SLAVES(3), .REGION_BITS(12), .ERR_CNT_W(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSELx(HSELx), .HRDATAx(HRDATAx), .HREADYOUTx(HREADYOUTx), .HRESPx(HRESPx),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          cyc;
    string       nm;
    bit          chk_sel;
    logic [2:0]  sel;
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge HCLK) cyc++;

  task automatic cmp(input exp_t e);
    if (e.chk_sel) begin
      n_checks++;
      if (HSELx !== e.sel) begin
        n_errors++;
        $display("FAIL %s hsel: got %b expected %b", e.nm, HSELx, e.sel);
      end
    end
    n_checks++;
    if (HREADY !== e.rdy) begin
      n_errors++;
      $display("FAIL %s hready: got %b expected %b", e.nm, HREADY, e.rdy);
    end
    n_checks++;
    if (HRESP !== e.resp) begin
      n_errors++;
      $display("FAIL %s hresp: got %b expected %b", e.nm, HRESP, e.resp);
    end
    n_checks++;
    if (HRDATA !== e.data) begin
      n_errors++;
      $display("FAIL %s hrdata: got %h expected %h", e.nm, HRDATA, e.data);
    end
    n_checks++;
    if (err_count !== e.cnt) begin
      n_errors++;
      $display("FAIL %s err_count: got %0d expected %0d", e.nm, err_count, e.cnt);
    end
    $display("cyc %0d %s: sel=%b rdy=%b resp=%b data=%h cnt=%0d",
             e.cyc, e.nm, HSELx, HREADY, HRESP, HRDATA, err_count);
  endtask

  // Monitor: compares every expectation tagged with the current cycle.
  initial begin
    forever begin
      @(negedge HCLK);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s stale: got cycle %0d expected cycle %0d", e.nm, cyc, e.cyc);
        end else begin
          cmp(e);
        end
      end
    end
  end

  task automatic expect_now(input string nm, input bit chk_sel, input logic [2:0] sel,
                            input logic rdy, input logic resp, input logic [31:0] data,
                            input logic [1:0] cnt);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.chk_sel = chk_sel; e.sel = sel;
    e.rdy = rdy; e.resp = resp; e.data = data; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(input logic [31:0] a, input logic [1:0] t);
    HADDR  = a;
    HTRANS = t;
  endtask

  initial begin
    exp_t e_now;
    HRESETn = 1'b0; err_clr = 1'b0;
    HADDR = '0; HTRANS = T_IDLE;
    HREADYOUTx = 3'b111; HRESPx = 3'b000;
    sd0 = D0; sd1 = D1; sd2 = 32'h0;
    tick();

    // Reset state and decode
    drv(32'h1000, T_NSEQ); expect_now("reset", 1, 3'b010, 1, 0, 32'h0, 2'd0); tick();
    HRESETn = 1'b1;
    expect_now("rel_dec", 1, 3'b010, 1, 0, 32'h0, 2'd0); tick();

    // Slave 1 data phase, read 0x2004 in address phase
    drv(32'h2004, T_NSEQ); expect_now("s1_data", 1, 3'b100, 1, 0, D1, 2'd0); tick();
    drv(32'h0, T_IDLE); HREADYOUTx = 3'b011;
    expect_now("s2_wait1", 1, 3'b001, 0, 0, 32'h0, 2'd0); tick();
    expect_now("s2_wait2", 1, 3'b001, 0, 0, 32'h0, 2'd0); tick();
    HREADYOUTx = 3'b111; sd2 = 32'hDEAD_BEEF;
    expect_now("s2_done", 1, 3'b001, 1, 0, 32'hDEAD_BEEF, 2'd0); tick();

    // Unmapped active transfer
    drv(32'h5000, T_NSEQ); expect_now("unm_addr", 1, 3'b000, 1, 0, D0, 2'd0); tick();
    drv(32'h0, T_IDLE);    expect_now("unm_err1", 1, 3'b001, 0, 1, 32'h0, 2'd0); tick();
    expect_now("unm_err2", 1, 3'b001, 1, 1, 32'h0, 2'd0); tick();

    // Unmapped idle: zero-wait OKAY
    drv(32'h5000, T_IDLE); expect_now("idl_addr", 1, 3'b000, 1, 0, D0, 2'd1); tick();
    drv(32'h0, T_IDLE);    expect_now("idl_okay", 1, 3'b001, 1, 0, 32'h0, 2'd1); tick();

    // Pipelined switch slave 0 (one wait) -> slave 1
    drv(32'h0, T_NSEQ);    expect_now("sw_s0a", 1, 3'b001, 1, 0, D0, 2'd1); tick();
    drv(32'h1000, T_NSEQ); HREADYOUTx = 3'b110;
    expect_now("sw_wait", 1, 3'b010, 0, 0, D0, 2'd1); tick();
    HREADYOUTx = 3'b111;
    expect_now("sw_s0d", 1, 3'b010, 1, 0, D0, 2'd1); tick();
    drv(32'h0, T_IDLE);    expect_now("sw_s1d", 1, 3'b001, 1, 0, D1, 2'd1); tick();

    // Slave ERROR passthrough counts too
    HRESPx = 3'b001;       expect_now("s_err", 1, 3'b001, 1, 1, D0, 2'd1); tick();
    HRESPx = 3'b000;       expect_now("s_err_cnt", 1, 3'b001, 1, 0, D0, 2'd2); tick();
    err_clr = 1'b1;        expect_now("clr", 0, 3'b000, 1, 0, D0, 2'd2); tick();
    err_clr = 1'b0;

    // Five back-to-back unmapped NONSEQs: counter saturates, clear on last ERR2
    drv(32'h5000, T_NSEQ); expect_now("sat_addr", 1, 3'b000, 1, 0, D0, 2'd0); tick();
    for (int k = 0; k < 5; k++) begin
      logic [1:0] c;
      c = (k > 3) ? 2'd3 : 2'(k);
      expect_now($sformatf("sat_err1_%0d", k), 1, 3'b000, 0, 1, 32'h0, c); tick();
      if (k == 4) begin
        drv(32'h0, T_IDLE); err_clr = 1'b1;
      end
      expect_now($sformatf("sat_err2_%0d", k), 0, 3'b000, 1, 1, 32'h0, c); tick();
    end
    err_clr = 1'b0;
    expect_now("clr_win", 1, 3'b001, 1, 0, D0, 2'd0); tick();

    // Reset during ERR1
    drv(32'h5000, T_NSEQ); expect_now("rst_addr", 1, 3'b000, 1, 0, D0, 2'd0); tick();
    expect_now("rst_err1", 1, 3'b000, 0, 1, 32'h0, 2'd0);
    @(negedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    e_now.cyc = cyc; e_now.nm = "rst_async"; e_now.chk_sel = 0; e_now.sel = 3'b000;
    e_now.rdy = 1; e_now.resp = 0; e_now.data = 32'h0; e_now.cnt = 2'd0;
    cmp(e_now);
    tick();
    drv(32'h0, T_IDLE);    expect_now("rst_hold", 1, 3'b001, 1, 0, 32'h0, 2'd0); tick();
    HRESETn = 1'b1;        expect_now("rst_noerr2", 1, 3'b001, 1, 0, 32'h0, 2'd0); tick();
    expect_now("rst_after", 1, 3'b001, 1, 0, D0, 2'd0); tick();

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge HCLK);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
